// File: rtl/lsh_frame_norm_if.sv
// Handshake bundle for lsh_frame_norm: sample input stream and shifted output stream.
// master = upstream/downstream side, slave = the normalizer.
interface lsh_frame_norm_if #(
  parameter int W  = 8,
  parameter int SW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [SW-1:0] out_shft;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_shft
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_shft
  );
endinterface

// File: rtl/lsh_frame_norm.sv
// Block-floating-point normalizer: buffers one frame, left-shifts it by its common headroom
// (clamped to MAX_SHFT) and reports the shift. Optional bypass port: LSH_FRAME_NORM_BYPASS_EN.
module lsh_frame_norm #(
  parameter int N        = 3,
  parameter int FRAME    = 8,
  parameter int MAX_SHFT = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef LSH_FRAME_NORM_BYPASS_EN
  input  logic bypass,
`endif
  lsh_frame_norm_if.slave bus
);
  localparam int W  = 2**N;
  localparam int HW = $clog2(W);
  localparam int SW = $clog2(MAX_SHFT + 1);
  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Redundant sign bits below the MSB, 0..W-1.
  function automatic logic [HW-1:0] headroom(input logic [W-1:0] x);
    logic [HW-1:0] h;
    logic          done;
    h    = '0;
    done = 1'b0;
    for (int i = W - 2; i >= 0; i--) begin
      if (!done && (x[i] == x[W-1])) begin
        h = h + HW'(1);
      end else begin
        done = 1'b1;
      end
    end
    return h;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [HW-1:0] hmin_q, hmin_d;
  logic [SW-1:0] shft_q, shft_d;
  logic [W-1:0]  sbuf_q [FRAME];
  logic [W-1:0]  sbuf_d [FRAME];
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic          in_fire_s;
  logic          out_fire_s;
  logic [HW-1:0] hdrm_s;
  logic [HW-1:0] hmin_nxt_s;
  logic [SW-1:0] shft_new_s;
  logic [CW-1:0] rd_nxt_s;

  assign in_fire_s  = bus.in_valid & in_ready_q;
  assign out_fire_s = out_valid_q & bus.out_ready;
  assign hdrm_s     = headroom(bus.in_data);
  assign hmin_nxt_s = (hdrm_s < hmin_q) ? hdrm_s : hmin_q;
  assign rd_nxt_s   = rd_cnt_q + CW'(1);

  always_comb begin
    shft_new_s = (hmin_nxt_s < HW'(MAX_SHFT)) ? SW'(hmin_nxt_s) : SW'(MAX_SHFT);
`ifdef LSH_FRAME_NORM_BYPASS_EN
    if (bypass) begin
      shft_new_s = '0;
    end else begin
      shft_new_s = shft_new_s;
    end
`endif
  end

  // Outputs are registered, so each transition also preloads the next output word.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    hmin_d      = hmin_q;
    shft_d      = shft_q;
    sbuf_d      = sbuf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      FILL: begin
        if (in_fire_s) begin
          sbuf_d[wr_cnt_q] = bus.in_data;
          hmin_d           = hmin_nxt_s;
          if (wr_cnt_q == LAST_IDX) begin
            state_d     = DRAIN;
            shft_d      = shft_new_s;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = sbuf_q[0] << shft_new_s;
            out_last_d  = 1'b0;
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end else begin
          state_d = FILL;
        end
      end
      DRAIN: begin
        if (out_fire_s) begin
          if (rd_cnt_q == LAST_IDX) begin
            state_d     = FILL;
            rd_cnt_d    = '0;
            wr_cnt_d    = '0;
            hmin_d      = HW'(W - 1);
            shft_d      = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
          end else begin
            rd_cnt_d   = rd_nxt_s;
            out_data_d = sbuf_q[rd_nxt_s] << shft_q;
            out_last_d = (rd_nxt_s == LAST_IDX);
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d     = FILL;
        rd_cnt_d    = '0;
        wr_cnt_d    = '0;
        hmin_d      = HW'(W - 1);
        shft_d      = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      hmin_q      <= HW'(W - 1);
      shft_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < FRAME; i++) begin
        sbuf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      hmin_q      <= hmin_d;
      shft_q      <= shft_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      for (int i = 0; i < FRAME; i++) begin
        sbuf_q[i] <= sbuf_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_shft  = shft_q;
endmodule

// File: tb/tb_lsh_frame_norm.sv
// Scoreboard bench for lsh_frame_norm: a reference model predicts each frame's output,
// a monitor pops and compares on every output transfer.
module tb_lsh_frame_norm;
  localparam int N        = 3;
  localparam int W        = 8;
  localparam int FRAME    = 8;
  localparam int MAX_SHFT = 2;
  localparam int SW       = 2;

  typedef struct packed {
    logic [W-1:0]  d;
    logic          last;
    logic [SW-1:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic hold_low;
  logic rdy_rand;
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;
  exp_t sb[$];
  logic [W-1:0] frm [FRAME];
  logic         stall_seen;
  logic [W-1:0] stall_data;
`ifdef LSH_FRAME_NORM_BYPASS_EN
  logic bypass;
  logic byp_last;
`endif

  always #5 clk = ~clk;

  lsh_frame_norm_if #(.W(W), .SW(SW)) bus ();

  lsh_frame_norm #(.N(N), .FRAME(FRAME), .MAX_SHFT(MAX_SHFT)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef LSH_FRAME_NORM_BYPASS_EN
    .bypass (bypass),
`endif
    .bus    (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Headroom as the largest h for which the value fits in W-h signed bits.
  function automatic int ref_headroom(input logic [W-1:0] x);
    int v;
    int lim;
    v = int'($signed(x));
    for (int h = W - 1; h >= 0; h--) begin
      lim = 1 << (W - 1 - h);
      if (v >= -lim && v < lim) return h;
    end
    return 0;
  endfunction

  task automatic push_frame_expect();
    int   hmin;
    int   sh;
    exp_t e;
    hmin = W - 1;
    for (int i = 0; i < FRAME; i++) begin
      if (ref_headroom(frm[i]) < hmin) hmin = ref_headroom(frm[i]);
    end
    sh = (hmin < MAX_SHFT) ? hmin : MAX_SHFT;
`ifdef LSH_FRAME_NORM_BYPASS_EN
    if (byp_last) sh = 0;
`endif
    for (int i = 0; i < FRAME; i++) begin
      e.d    = W'(int'($signed(frm[i])) * (1 << sh));
      e.last = (i == FRAME - 1);
      e.s    = SW'(sh);
      sb.push_back(e);
    end
  endtask

  task automatic send_sample(input logic [W-1:0] d);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
  endtask

  task automatic send_frame();
    push_frame_expect();
    for (int i = 0; i < FRAME; i++) begin
`ifdef LSH_FRAME_NORM_BYPASS_EN
      bypass = (i == FRAME - 1) ? byp_last : 1'($urandom_range(0, 1));
`endif
      send_sample(frm[i]);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_frame();
    logic signed [W-1:0] t;
    for (int i = 0; i < FRAME; i++) begin
      t = W'($urandom);
      frm[i] = t >>> $urandom_range(0, W - 1);
    end
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_shft", int'(bus.out_shft), 0);
    check("rst_out_last", int'(bus.out_last), 0);
  endtask

  // Downstream ready: always high, random, or forced low for the stall test.
  always @(posedge clk) begin
    #2;
    bus.out_ready = hold_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: pop and compare on each transfer, check idle zeros and stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      check("ready_vs_valid", int'(bus.in_ready), int'(!bus.out_valid));
      if (bus.out_valid) begin
        if (stall_seen) check("stall_hold", int'(bus.out_data), int'(stall_data));
        if (bus.out_ready) begin
          stall_seen = 1'b0;
          if (sb.size() == 0) begin
            check("unexpected_out", int'(bus.out_data), -1);
          end else begin
            e = sb.pop_front();
            check("out_data", int'(bus.out_data), int'(e.d));
            check("out_last", int'(bus.out_last), int'(e.last));
            check("out_shft", int'(bus.out_shft), int'(e.s));
            acc_cnt++;
          end
        end else begin
          stall_seen = 1'b1;
          stall_data = bus.out_data;
        end
      end else begin
        stall_seen = 1'b0;
        check("idle_zero", int'({bus.out_data, bus.out_last, bus.out_shft}), 0);
      end
    end
  end

  initial begin
    int base;
    int t;
    rst          = 1'b1;
    hold_low     = 1'b0;
    rdy_rand     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
`ifdef LSH_FRAME_NORM_BYPASS_EN
    bypass   = 1'b0;
    byp_last = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    // Mixed headroom frame, hmin=3 clamped to 2.
    frm = '{8'h0F, 8'hF0, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_drain();

    // Full-scale sample forces zero shift.
    rand_frame();
    frm[3] = 8'h80;
    send_frame();
    wait_drain();

    // Stall mid-drain while upstream keeps offering a sample.
    rand_frame();
    send_frame();
    base = acc_cnt;
    t = 0;
    while (acc_cnt < base + 3 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("bp_reach_timeout", int'(acc_cnt >= base + 3), 1);
    #1;
    hold_low     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (6) @(posedge clk);
    #1;
    check("bp_out_valid_held", int'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    hold_low     = 1'b0;
    wait_drain();

    // Partial frame discarded by reset, then a fresh frame.
    rand_frame();
    for (int i = 0; i < 4; i++) send_sample(8'h40);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();
    frm = '{8'h03, 8'hFE, 8'h00, 8'h01, 8'hFC, 8'h02, 8'hFF, 8'h00};
    send_frame();
    wait_drain();

`ifdef LSH_FRAME_NORM_BYPASS_EN
    frm = '{8'h0F, 8'hF0, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    byp_last = 1'b1;
    send_frame();
    wait_drain();
    byp_last = 1'b0;
`endif

    // Random frames back-to-back with random downstream ready.
    rdy_rand = 1'b1;
    for (int f = 0; f < 25; f++) begin
`ifdef LSH_FRAME_NORM_BYPASS_EN
      byp_last = 1'($urandom_range(0, 3) == 0);
`endif
      rand_frame();
      send_frame();
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
